sonic_sensor_responder: RTL and testbench

Ultrasonic ranging sensor emulator: the responder end of the single-wire trigger/echo protocol that the sonic sensor controller drives on `sig_out`. It watches the shared bidirectional line for a host trigger pulse, waits a fixed hold-off, then drives an echo pulse whose width in clock cycles is programmed by a 32-bit register. It sits on the bench/HIL side of the board, letting the sensor controller and its FIFO path run without a physical sensor.

---
 rtl/sonic_sensor_responder.sv | 174 +++++++++++++++++
 tb/tb_sonic_sensor_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sonic_sensor_responder.sv
// sonic_sensor_responder
// Ultrasonic ranging sensor emulator. Watches the shared trigger/echo line for a
// host trigger pulse, waits a fixed hold-off, then drives an echo pulse whose
// width (in clock cycles) comes from a programmable length register. The line is
// only ever driven high or released; an external pull-down provides the low level.

module sonic_sensor_responder #(
  parameter logic [31:0] MIN_TRIG     = 32'd200,
  parameter logic [31:0] HOLDOFF      = 32'd75000,
  parameter logic [31:0] MAX_ECHO     = 32'd1850000,
  parameter logic [31:0] RECOVER      = 32'd20000,
  parameter logic [31:0] DEFAULT_ECHO = 32'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] echo_len,
  input  logic        echo_len_wr,
  inout  wire         sig,
  output logic        busy,
  output logic        resp_done,
  output logic        short_trig,
  output logic [15:0] ping_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_HOLDOFF,
    ST_ECHO,
    ST_RECOVER
  } state_t;

  state_t      state_reg;
  logic [1:0]  sync_reg;
  logic        sig_prev_reg;
  logic [31:0] cnt_reg;
  logic [31:0] len_reg;
  logic [31:0] len_lat_reg;
  logic [31:0] len_clamped;
  logic        drive_reg;
  logic        busy_reg;
  logic        resp_done_reg;
  logic        short_trig_reg;
  logic [15:0] ping_count_reg;
  logic        sig_s;
  logic        sig_rise;

  // Line is driven high only during the echo; the async reset clears drive_reg,
  // so the line is released the moment rst_n falls.
  assign sig = drive_reg ? 1'b1 : 1'bz;

  assign sig_s    = sync_reg[1];
  // Rising edge relative to the previous synchronized sample: a line already
  // high when IDLE is entered never looks like a fresh trigger.
  assign sig_rise = sig_s & ~sig_prev_reg;

  assign busy       = busy_reg;
  assign resp_done  = resp_done_reg;
  assign short_trig = short_trig_reg;
  assign ping_count = ping_count_reg;

  // Two-flop synchronizer for the shared line plus a delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= 2'b00;
      sig_prev_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], sig};
      sig_prev_reg <= sig_s;
    end
  end

  // Host-programmable echo length; accepted in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg <= DEFAULT_ECHO;
    end else if (echo_len_wr) begin
      len_reg <= echo_len;
    end
  end

  // Effective echo length: zero becomes one cycle, long requests hit the timeout clamp.
  always_comb begin
    len_clamped = len_reg;
    if (len_reg == 32'd0) begin
      len_clamped = 32'd1;
    end else if (len_reg > MAX_ECHO) begin
      len_clamped = MAX_ECHO;
    end
  end

  // Responder state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 32'd0;
      len_lat_reg    <= 32'd0;
      drive_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      resp_done_reg  <= 1'b0;
      short_trig_reg <= 1'b0;
      ping_count_reg <= 16'd0;
    end else begin
      resp_done_reg  <= 1'b0;
      short_trig_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (sig_rise) begin
            state_reg <= ST_TRIG;
            cnt_reg   <= 32'd1;
            busy_reg  <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (sig_s) begin
            // Saturating width measurement; a stuck-high line simply stays here.
            if (cnt_reg < MIN_TRIG) begin
              cnt_reg <= cnt_reg + 32'd1;
            end
          end else if (cnt_reg >= MIN_TRIG) begin
            state_reg      <= ST_HOLDOFF;
            cnt_reg        <= 32'd0;
            ping_count_reg <= ping_count_reg + 16'd1;
            // Uses the pre-write register value if a write lands on this same edge.
            len_lat_reg    <= len_clamped;
          end else begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            short_trig_reg <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_reg == HOLDOFF - 32'd1) begin
            state_reg     <= ST_ECHO;
            cnt_reg       <= 32'd0;
            drive_reg     <= 1'b1;
            // A one-cycle echo is also its own last cycle.
            resp_done_reg <= (len_lat_reg == 32'd1);
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        ST_ECHO: begin
          if (cnt_reg == len_lat_reg - 32'd1) begin
            state_reg <= ST_RECOVER;
            cnt_reg   <= 32'd0;
            drive_reg <= 1'b0;
          end else begin
            cnt_reg       <= cnt_reg + 32'd1;
            // Flag the cycle in which cnt_reg will reach the final count.
            resp_done_reg <= (cnt_reg + 32'd2 == len_lat_reg);
          end
        end
        ST_RECOVER: begin
          // Line activity is deliberately ignored during the dead time.
          if (cnt_reg == RECOVER - 32'd1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 32'd0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= 32'd0;
          drive_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_sensor_responder.sv
// Testbench for sonic_sensor_responder: table of directed pings plus hand-written
// sequences for mid-echo writes, write/latch collision, trigger during recovery
// and reset during the echo.

module tb_sonic_sensor_responder;

  localparam logic [31:0] P_MIN  = 32'd4;
  localparam logic [31:0] P_HOLD = 32'd10;
  localparam logic [31:0] P_MAX  = 32'd100;
  localparam logic [31:0] P_REC  = 32'd8;
  localparam logic [31:0] P_DEF  = 32'd1000;
  // Echo starts this many samples after E0: two synchronizer cycles plus hold-off.
  localparam int ECHO_START = 2 + 10;
  localparam int REC_CYC    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] echo_len = 32'd0;
  logic        echo_len_wr = 1'b0;
  logic        host_drive = 1'b0;
  wire         sig_line;
  logic        busy;
  logic        resp_done;
  logic        short_trig;
  logic [15:0] ping_count;

  int checks = 0;
  int failures = 0;
  int ping_model = 0;

  assign sig_line = host_drive ? 1'b1 : 1'bz;
  pulldown pd_line (sig_line);

  always #5 clk = ~clk;

  sonic_sensor_responder #(
    .MIN_TRIG    (P_MIN),
    .HOLDOFF     (P_HOLD),
    .MAX_ECHO    (P_MAX),
    .RECOVER     (P_REC),
    .DEFAULT_ECHO(P_DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .echo_len   (echo_len),
    .echo_len_wr(echo_len_wr),
    .sig        (sig_line),
    .busy       (busy),
    .resp_done  (resp_done),
    .short_trig (short_trig),
    .ping_count (ping_count)
  );

  typedef struct {
    string       name;
    int          trig;
    bit          wr;
    logic [31:0] len;
    int          exp_len;
    bit          exp_short;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One ping: optional length write, host trigger of 'trig' cycles, then sample
  // every negedge after E0 and check echo position/width, resp_done, busy, count.
  task automatic do_ping(input string name, input int trig, input bit wr,
                         input logic [31:0] len, input int exp_len, input bit exp_short,
                         input int mid_idx, input logic [31:0] mid_val,
                         input int rst_idx, input bit rec_trig);
    int first, last, hi, rd, rd_idx, st, last_j, bad;
    logic busy_prev, busy_last;
    first = -1; last = -1; hi = 0; rd = 0; rd_idx = -1; st = 0; bad = 0;
    busy_prev = 1'b0; busy_last = 1'b0;
    if (wr) begin
      @(negedge clk);
      echo_len = len;
      echo_len_wr = 1'b1;
      @(negedge clk);
      echo_len_wr = 1'b0;
    end
    @(negedge clk);
    host_drive = 1'b1;
    repeat (trig) @(negedge clk);
    host_drive = 1'b0;
    last_j = exp_short ? 5 : ECHO_START + exp_len + REC_CYC;
    for (int j = 0; j <= last_j; j++) begin
      @(negedge clk);
      if (!host_drive && sig_line) begin
        if (first < 0) first = j;
        last = j;
        hi++;
      end
      if (resp_done) begin
        rd++;
        rd_idx = j;
      end
      if (short_trig) st++;
      busy_prev = busy_last;
      busy_last = busy;
      if (j == mid_idx) begin
        echo_len = mid_val;
        echo_len_wr = 1'b1;
      end else begin
        echo_len_wr = 1'b0;
      end
      if (rec_trig && j == ECHO_START + exp_len + 1) host_drive = 1'b1;
      if (j == rst_idx) begin
        rst_n = 1'b0;
        #1;
        chk({name, " rst sig released"}, int'(sig_line), 0);
        chk({name, " rst busy"}, int'(busy), 0);
        chk({name, " rst ping_count"}, int'(ping_count), 0);
        chk({name, " rst resp_done"}, int'(resp_done), 0);
        chk({name, " echo cycles before rst"}, hi, rst_idx - ECHO_START + 1);
        chk({name, " resp_done before rst"}, rd, 0);
        ping_model = 0;
        repeat (3) begin
          @(negedge clk);
          if (resp_done || busy || sig_line || short_trig) bad++;
        end
        chk({name, " quiet in reset"}, bad, 0);
        rst_n = 1'b1;
        $display("ping %-16s reset at sample %0d after %0d echo cycles", name, j, hi);
        return;
      end
    end
    echo_len_wr = 1'b0;
    if (exp_short) begin
      chk({name, " short_trig pulses"}, st, 1);
      chk({name, " echo cycles"}, hi, 0);
      chk({name, " resp_done pulses"}, rd, 0);
      chk({name, " busy after reject"}, int'(busy_last), 0);
    end else begin
      ping_model++;
      chk({name, " echo start"}, first, ECHO_START);
      chk({name, " echo width"}, hi, exp_len);
      chk({name, " echo last"}, last, ECHO_START + exp_len - 1);
      chk({name, " resp_done pulses"}, rd, 1);
      chk({name, " resp_done at"}, rd_idx, ECHO_START + exp_len - 1);
      chk({name, " short_trig"}, st, 0);
      chk({name, " busy before fall"}, int'(busy_prev), 1);
      chk({name, " busy after recover"}, int'(busy_last), 0);
    end
    chk({name, " ping_count"}, int'(ping_count), ping_model & 16'hFFFF);
    $display("ping %-16s trig=%0d echo=%0d start=%0d done_at=%0d short=%0d count=%0d",
             name, trig, hi, first, rd_idx, st, ping_count);
  endtask

  initial begin
    int bad;
    vecs[0] = '{"default_len", 10, 1'b0, 32'd0,   100, 1'b0};
    vecs[1] = '{"len20",       10, 1'b1, 32'd20,  20,  1'b0};
    vecs[2] = '{"trig2_short",  2, 1'b0, 32'd0,   0,   1'b1};
    vecs[3] = '{"len500_clamp", 4, 1'b1, 32'd500, 100, 1'b0};
    vecs[4] = '{"trig3_short",  3, 1'b0, 32'd0,   0,   1'b1};
    vecs[5] = '{"len0_to_1",    6, 1'b1, 32'd0,   1,   1'b0};
    vecs[6] = '{"len100_max",   5, 1'b1, 32'd100, 100, 1'b0};
    vecs[7] = '{"len101_clamp", 5, 1'b1, 32'd101, 100, 1'b0};
    vecs[8] = '{"len2",         5, 1'b1, 32'd2,   2,   1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset sig", int'(sig_line), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset resp_done", int'(resp_done), 0);
    chk("reset short_trig", int'(short_trig), 0);
    chk("reset ping_count", int'(ping_count), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_ping(vecs[i].name, vecs[i].trig, vecs[i].wr, vecs[i].len,
              vecs[i].exp_len, vecs[i].exp_short, -1, 32'd0, -1, 1'b0);
    end

    // Write during echo affects only the next ping
    do_ping("wr_mid_echo", 10, 1'b1, 32'd20, 20, 1'b0, ECHO_START + 3, 32'd30, -1, 1'b0);
    do_ping("after_mid_wr", 10, 1'b0, 32'd0, 30, 1'b0, -1, 32'd0, -1, 1'b0);

    // Write on the same edge as the hold-off latch: old value is used
    do_ping("wr_at_latch", 10, 1'b0, 32'd0, 30, 1'b0, 1, 32'd7, -1, 1'b0);
    do_ping("after_latch_wr", 10, 1'b0, 32'd0, 7, 1'b0, -1, 32'd0, -1, 1'b0);

    // Trigger during recovery, still high at IDLE entry: must be ignored
    do_ping("rec_trig", 10, 1'b1, 32'd5, 5, 1'b0, -1, 32'd0, -1, 1'b1);
    repeat (2) @(negedge clk);
    host_drive = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy || sig_line || resp_done || short_trig) bad++;
    end
    chk("recover trigger ignored", bad, 0);
    chk("recover ping_count", int'(ping_count), ping_model);
    $display("seq recover_trigger quiet_cycles_bad=%0d count=%0d", bad, ping_count);
    do_ping("after_rec_trig", 8, 1'b1, 32'd6, 6, 1'b0, -1, 32'd0, -1, 1'b0);

    // Reset on the fifth echo cycle, then a normal ping
    do_ping("rst_mid_echo", 10, 1'b1, 32'd20, 20, 1'b0, -1, 32'd0, ECHO_START + 4, 1'b0);
    do_ping("after_reset", 10, 1'b1, 32'd8, 8, 1'b0, -1, 32'd0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
